// File: rtl/switch_box_scan.sv
// Scan-configured switch box: serial shadow load, atomic commit, disjoint/Wilton routing.
// Define SB_OUTPUT_REG_EN to register the four outputs (1-cycle routing latency).
module switch_box_scan #(
   parameter int W    = 8,
   parameter int TOPO = 0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cset,
   input  logic         cin,
   output logic         cout,
   input  logic         commit,
   output logic         cfg_valid,
   output logic         err,
   input  logic [W-1:0] north_in,
   input  logic [W-1:0] east_in,
   input  logic [W-1:0] south_in,
   input  logic [W-1:0] west_in,
   output logic [W-1:0] north_out,
   output logic [W-1:0] east_out,
   output logic [W-1:0] south_out,
   output logic [W-1:0] west_out
);
   localparam int CW   = 8 * W;
   localparam int CNTW = $clog2(CW + 1);
   localparam logic [CNTW-1:0] CNT_FULL = CNTW'(CW);

   logic [CW-1:0]   sh;
   logic [CW-1:0]   act;
   logic [CNTW-1:0] cnt;

   // Shadow chain shifts freely; act only ever changes on an accepted commit.
   always_ff @(posedge clk) begin
      if (!rst) begin
         sh        <= '0;
         act       <= '0;
         cnt       <= '0;
         cfg_valid <= 1'b0;
         err       <= 1'b0;
      end else begin
         err <= 1'b0;
         if (cset) begin
            sh <= {cin, sh[CW-1:1]};
            if (cnt != CNT_FULL) cnt <= cnt + CNTW'(1);
            if (commit) err <= 1'b1;
         end else if (commit) begin
            if (cnt == CNT_FULL) begin
               act       <= sh;
               cfg_valid <= 1'b1;
               cnt       <= '0;
            end else begin
               err <= 1'b1;
            end
         end
      end
   end

   assign cout = sh[0];

   logic [W-1:0] rn, re, rs, rw;

   for (genvar k = 0; k < W; k++) begin : g_trk
      // Turns pick the neighbouring track under Wilton; straight paths stay on k.
      localparam int KP = (TOPO == 1) ? ((k + 1) % W) : k;
      localparam int KM = (TOPO == 1) ? ((k + W - 1) % W) : k;
      logic [7:0] f;
      logic       no_k, eo_k, so_k, wo_k;

      assign f = act[8*k +: 8];

      always_comb begin
         no_k = 1'b0;
         eo_k = 1'b0;
         so_k = 1'b0;
         wo_k = 1'b0;
         case (f[1:0])
            2'd0:    no_k = east_in[KP];
            2'd1:    no_k = south_in[k];
            2'd2:    no_k = west_in[KM];
            default: no_k = 1'b0;
         endcase
         case (f[3:2])
            2'd0:    eo_k = south_in[KP];
            2'd1:    eo_k = west_in[k];
            2'd2:    eo_k = north_in[KM];
            default: eo_k = 1'b0;
         endcase
         case (f[5:4])
            2'd0:    so_k = west_in[KP];
            2'd1:    so_k = north_in[k];
            2'd2:    so_k = east_in[KM];
            default: so_k = 1'b0;
         endcase
         case (f[7:6])
            2'd0:    wo_k = north_in[KP];
            2'd1:    wo_k = east_in[k];
            2'd2:    wo_k = south_in[KM];
            default: wo_k = 1'b0;
         endcase
      end

      assign rn[k] = no_k & cfg_valid;
      assign re[k] = eo_k & cfg_valid;
      assign rs[k] = so_k & cfg_valid;
      assign rw[k] = wo_k & cfg_valid;
   end

`ifdef SB_OUTPUT_REG_EN
   always_ff @(posedge clk) begin
      if (!rst) begin
         north_out <= '0;
         east_out  <= '0;
         south_out <= '0;
         west_out  <= '0;
      end else begin
         north_out <= rn;
         east_out  <= re;
         south_out <= rs;
         west_out  <= rw;
      end
   end
`else
   assign north_out = rn;
   assign east_out  = re;
   assign south_out = rs;
   assign west_out  = rw;
`endif

endmodule

// File: tb/tb_switch_box_scan.sv
// Directed bench for switch_box_scan: a disjoint and a Wilton instance share one config stream.
module tb_switch_box_scan;
   logic       clk = 1'b0;
   logic       rst, cset, cin, commit;
   logic [7:0] ni, ei, si, wi;
   logic       cout0, cout1, cv0, cv1, err0, err1;
   logic [7:0] no0, eo0, so0, wo0, no1, eo1, so1, wo1;
   int         tests = 0;
   int         fails = 0;
   logic [63:0] pat;

   always #5 clk = ~clk;

   switch_box_scan #(.W(8), .TOPO(0)) dut0 (
      .clk(clk), .rst(rst), .cset(cset), .cin(cin), .cout(cout0), .commit(commit),
      .cfg_valid(cv0), .err(err0),
      .north_in(ni), .east_in(ei), .south_in(si), .west_in(wi),
      .north_out(no0), .east_out(eo0), .south_out(so0), .west_out(wo0));

   switch_box_scan #(.W(8), .TOPO(1)) dut1 (
      .clk(clk), .rst(rst), .cset(cset), .cin(cin), .cout(cout1), .commit(commit),
      .cfg_valid(cv1), .err(err1),
      .north_in(ni), .east_in(ei), .south_in(si), .west_in(wi),
      .north_out(no1), .east_out(eo1), .south_out(so1), .west_out(wo1));

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Outputs reflect current inputs: combinationally, or after one edge when registered.
   task automatic settle();
`ifdef SB_OUTPUT_REG_EN
      tick();
`else
      #1;
`endif
   endtask

   task automatic shift_pat(input logic [63:0] p, input int from, input int to);
      for (int j = from; j < to; j++) begin
         cset = 1'b1;
         cin  = p[j];
         tick();
      end
      cset = 1'b0;
      cin  = 1'b0;
   endtask

   task automatic do_commit();
      commit = 1'b1;
      tick();
      commit = 1'b0;
   endtask

   initial begin
      rst = 1'b0; cset = 1'b0; cin = 1'b0; commit = 1'b0;
      ni = 8'hFF; ei = 8'hFF; si = 8'hFF; wi = 8'hFF;
      tick(); tick();
      chk("rst_cv", {7'd0, cv0}, 8'h00);
      chk("rst_cout", {7'd0, cout0}, 8'h00);
      chk("rst_err", {7'd0, err0}, 8'h00);
      chk("rst_no", no0, 8'h00);
      chk("rst_wo1", wo1, 8'h00);
      rst = 1'b1;
      settle();
      chk("unconf_eo", eo0, 8'h00);

      // 63 shifts: commit must be rejected
      shift_pat(64'd0, 0, 63);
      do_commit();
      chk("short_err", {7'd0, err0}, 8'h01);
      chk("short_cv", {7'd0, cv0}, 8'h00);
      settle();
      chk("short_so", so0, 8'h00);
      // shift + commit together: shift lands (cnt=64), commit ignored
      cset = 1'b1; commit = 1'b1; cin = 1'b0;
      tick();
      cset = 1'b0; commit = 1'b0;
      chk("both_err", {7'd0, err0}, 8'h01);
      chk("both_cv", {7'd0, cv0}, 8'h00);
      do_commit();
      chk("ok_err", {7'd0, err0}, 8'h00);
      chk("ok_cv", {7'd0, cv0}, 8'h01);
      chk("ok_cv1", {7'd0, cv1}, 8'h01);

      // all code 0: no<-east, eo<-south, so<-west, wo<-north
      ei = 8'hA5; si = 8'h3C; wi = 8'h0F; ni = 8'hF0;
      settle();
      chk("d0_no", no0, 8'hA5);
      chk("d0_eo", eo0, 8'h3C);
      chk("d0_so", so0, 8'h0F);
      chk("d0_wo", wo0, 8'hF0);

      // Wilton: no[k]=e[k+1], eo[k]=s[k+1]
      ni = 8'h00; ei = 8'h01; si = 8'h80; wi = 8'h00;
      settle();
      chk("w_no", no1, 8'h80);
      chk("w_eo", eo1, 8'h40);
      chk("d0_no_b", no0, 8'h01);
      chk("d0_eo_b", eo0, 8'h80);

      // one extra leading bit then all-code-2 (0xAA per track); sh keeps the last 64
      pat = {8{8'hAA}};
      cset = 1'b1; cin = 1'b1; tick();
      shift_pat(pat, 0, 64);
      do_commit();
      chk("over_err", {7'd0, err0}, 8'h00);
      ni = 8'h5A; wi = 8'hFF; ei = 8'h00; si = 8'h00;
      settle();
      chk("c2_no", no0, 8'hFF);
      chk("c2_eo", eo0, 8'h5A);
      chk("c2_so", so0, 8'h00);
      chk("w2_eo", eo1, 8'hB4);
      chk("w2_no", no1, 8'hFF);

      // load all-code-3; old routing holds, cout replays the previous stream
      for (int i = 0; i < 64; i++) begin
         chk("replay_cout", {7'd0, cout0}, {7'd0, pat[i]});
         if (i % 16 == 5) chk("hold_eo", eo0, 8'h5A);
         cset = 1'b1; cin = 1'b1;
         tick();
      end
      cset = 1'b0; cin = 1'b0;
      chk("hold_eo_end", eo0, 8'h5A);
      do_commit();
`ifdef SB_OUTPUT_REG_EN
      chk("c3_eo_lag", eo0, 8'h5A);
      tick();
`endif
      chk("c3_eo", eo0, 8'h00);
      chk("c3_no", no0, 8'h00);

      // reset mid-shift discards partial stream and count
      shift_pat({64{1'b1}}, 0, 30);
      rst = 1'b0; tick(); rst = 1'b1;
      chk("mrst_cv", {7'd0, cv0}, 8'h00);
      chk("mrst_cout", {7'd0, cout0}, 8'h00);
      pat = {8{8'h55}};
      shift_pat(pat, 0, 34);
      do_commit();
      chk("mrst_err", {7'd0, err0}, 8'h01);
      shift_pat(pat, 34, 64);
      do_commit();
      chk("fresh_err", {7'd0, err0}, 8'h00);
      chk("fresh_cv", {7'd0, cv0}, 8'h01);
      // all code 1: no<-south, eo<-west, so<-north, wo<-east (straight in both topologies)
      si = 8'hC3; wi = 8'h3C; ni = 8'h99; ei = 8'h66;
      settle();
      chk("c1_no", no0, 8'hC3);
      chk("c1_eo", eo0, 8'h3C);
      chk("c1_so", so0, 8'h99);
      chk("c1_wo", wo0, 8'h66);
      chk("c1_no1", no1, 8'hC3);
      chk("c1_wo1", wo1, 8'h66);
      tick();
      chk("err_clear", {7'd0, err0}, 8'h00);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
